sra_srl_iterative: RTL and testbench

- Multi-cycle right shifter: logical (SRL) and arithmetic (SRA) right shift of a 32-bit operand by a 5-bit amount.
- Serves as the right-shift counterpart to the ALU's combinational left shifter.
- Decomposes the shift into five binary stages of 1, 2, 4, 8 and 16 bits and applies one stage per clock.
- Uses a start/busy/done handshake, so the ALU control sequences it as a multi-cycle functional unit.

---
 rtl/sra_srl_iterative.sv | 108 ++++++++++
 tb/tb_sra_srl_iterative.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sra_srl_iterative.sv
// Multi-cycle right shifter: SRL/SRA of a WIDTH-bit operand, one binary
// stage (1, 2, 4, ... bits) per clock, sequenced by a start/busy/done handshake.
module sra_srl_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shiftamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [STG_W-1:0]   stage, stage_nx;
    logic [WIDTH-1:0]   work, work_nx;
    logic [SHAMT_W-1:0] amt, amt_nx;
    logic               fill, fill_nx;
    logic [WIDTH-1:0]   result_nx;

    // Candidate value for each stage: work shifted by 2^k with fill bits on top.
    logic [SHAMT_W-1:0][WIDTH-1:0] cand;
    logic [WIDTH-1:0]              stepped;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign cand[k] = {{SH{fill}}, work[WIDTH-1:SH]};
    end

    // Apply the current stage only if its amount bit is set.
    assign stepped = amt[stage] ? cand[stage] : work;

    // Outputs are decoded from the state register only.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            stage  <= '0;
            work   <= '0;
            amt    <= '0;
            fill   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nx;
            stage  <= stage_nx;
            work   <= work_nx;
            amt    <= amt_nx;
            fill   <= fill_nx;
            result <= result_nx;
        end
    end

    // Next-state and datapath update; every stage runs so latency is fixed.
    always_comb begin
        state_nx  = state;
        stage_nx  = stage;
        work_nx   = work;
        amt_nx    = amt;
        fill_nx   = fill;
        result_nx = result;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nx  = a;
                    amt_nx   = shiftamt;
                    fill_nx  = arith & a[WIDTH-1];
                    stage_nx = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                work_nx = stepped;
                if (stage == LAST_STG) begin
                    result_nx = stepped;
                    stage_nx  = '0;
                    state_nx  = DONE;
                end else begin
                    stage_nx = stage + STG_W'(1);
                end
            end
            DONE: begin
                // start is deliberately not sampled here.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                stage_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sra_srl_iterative.sv
// Directed self-checking bench for sra_srl_iterative.
module tb_sra_srl_iterative;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shiftamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    sra_srl_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .shiftamt (shiftamt),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One operation. Cycle i is the cycle after edge i (accept = edge 0).
    // If poke >= 0, a second start with other operands is pulsed in cycle poke.
    task automatic op(input string tag, input logic [31:0] av, input logic [4:0] sh,
                      input logic ar, input logic [31:0] exp, input int poke);
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clock);
        a = av; shiftamt = sh; arith = ar; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            if (i == poke) begin
                a = 32'hFFFF_FFFF; shiftamt = 5'd1; arith = 1'b0; start = 1'b1;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                chk({tag, " result@done"}, result, exp);
            end
        end
        start = 1'b0;
        chk({tag, " busy cycles"}, busy_cnt, 6);
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done cycle"}, done_at, 5);
        chk({tag, " result held"}, result, exp);
    endtask

    initial begin
        int done_cnt;
        int d0, d1;
        reset_n = 1'b0; start = 1'b0; a = '0; shiftamt = '0; arith = 1'b0;
        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle busy", busy, 0);

        op("srl31",   32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, -1);
        op("sra4neg", 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, -1);
        op("sra4pos", 32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF, -1);
        op("zero",    32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, -1);
        op("ignore",  32'h0000_FF00, 5'd8,  1'b0, 32'h0000_00FF, 2);

        // Reset between edges 3 and 4 of an operation.
        @(negedge clock);
        a = 32'hDEAD_BEEF; shiftamt = 5'd16; arith = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("midrst no done", done_cnt, 0);
        chk("midrst idle", busy, 0);
        op("sra16", 32'hDEAD_BEEF, 5'd16, 1'b1, 32'hFFFF_DEAD, -1);

        // Back-to-back with start held high.
        @(negedge clock);
        a = 32'h0000_0100; shiftamt = 5'd8; arith = 1'b0; start = 1'b1;
        d0 = -1; d1 = -1; done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (i == 0) begin
                a = 32'hF000_0000; shiftamt = 5'd28; arith = 1'b1;
            end
            if (i == 7) start = 1'b0;
            if (i == 6) chk("b2b idle gap", busy, 0);
            if (i == 7) chk("b2b second busy", busy, 1);
            if (done) begin
                done_cnt++;
                if (d0 < 0) begin
                    d0 = i;
                    chk("b2b result0", result, 32'h0000_0001);
                end else begin
                    d1 = i;
                    chk("b2b result1", result, 32'hFFFF_FFFF);
                end
            end
        end
        chk("b2b done count", done_cnt, 2);
        chk("b2b done0 cycle", d0, 5);
        chk("b2b done1 cycle", d1, 12);
        chk("b2b final idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
